// File: rtl/board_io_pkg.sv
// board_io_pkg: reset FSM encoding and default timing constants for the board input front end.
package board_io_pkg;
  typedef enum logic [1:0] {
    RST_ASSERT = 2'd0,
    RST_HOLD   = 2'd1,
    RUN        = 2'd2
  } rst_state_t;
  localparam int DEBOUNCE_CYCLES_DEF   = 1000000;
  localparam int RST_HOLD_CYCLES_DEF   = 16;
  localparam int LONG_PRESS_CYCLES_DEF = 100000000;
endpackage

// File: rtl/btn_debounce_ch.sv
// btn_debounce_ch: one button channel - polarity fix, 2-flop sync, debounce, edge pulses.
// Long-press counter exists only when BOARD_INPUT_LONG_PRESS_EN is defined.
module btn_debounce_ch import board_io_pkg::*; #(
  parameter bit ACTIVE_HIGH     = 1'b1,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
`ifdef BOARD_INPUT_LONG_PRESS_EN
  , parameter int LONG_PRESS_CYCLES = LONG_PRESS_CYCLES_DEF
`endif
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  logic [1:0] sync;
  logic [CW-1:0] cnt;
  logic diff, flip;
  assign diff = sync[1] ^ level;
  assign flip = diff && cnt == LAST;
  always_ff @(posedge clk)
    if (!rst_n) begin
      sync          <= '0;
      cnt           <= '0;
      level         <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      sync          <= {sync[0], raw ^ ~ACTIVE_HIGH};
      cnt           <= (diff && !flip) ? cnt + 1'b1 : '0;
      level         <= level ^ flip;
      press_pulse   <= flip && !level;
      release_pulse <= flip && level;
    end
`ifdef BOARD_INPUT_LONG_PRESS_EN
  localparam int LW = $clog2(LONG_PRESS_CYCLES + 1);
  localparam logic [LW-1:0] LMAX = LW'(LONG_PRESS_CYCLES);
  logic [LW-1:0] lcnt;
  // saturating at LMAX is what limits the pulse to once per press
  always_ff @(posedge clk)
    if (!rst_n) begin
      lcnt       <= '0;
      long_pulse <= 1'b0;
    end else begin
      lcnt       <= !level ? '0 : (lcnt == LMAX) ? lcnt : lcnt + 1'b1;
      long_pulse <= level && lcnt == LMAX - 1'b1;
    end
`else
  assign long_pulse = 1'b0;
`endif
endmodule

// File: rtl/board_input_conditioner.sv
// board_input_conditioner: debounced buttons with press/release pulses and a stretched,
// button-triggerable core reset. BOARD_INPUT_LONG_PRESS_EN enables btn_long.
module board_input_conditioner import board_io_pkg::*; #(
  parameter int               N_BTN             = 4,
  parameter logic [N_BTN-1:0] ACTIVE_HIGH_MASK  = {N_BTN{1'b1}},
  parameter int               DEBOUNCE_CYCLES   = DEBOUNCE_CYCLES_DEF,
  parameter int               RST_BTN_IDX       = 0,
  parameter int               RST_HOLD_CYCLES   = RST_HOLD_CYCLES_DEF,
  parameter int               LONG_PRESS_CYCLES = LONG_PRESS_CYCLES_DEF
) (
  input  logic             clk_100mhz,
  input  logic             ext_rst_n,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_long,
  output logic             sys_rst_n
);
  if (N_BTN < 1 || DEBOUNCE_CYCLES < 1 || RST_HOLD_CYCLES < 1 || LONG_PRESS_CYCLES < 1 ||
      RST_BTN_IDX < 0 || RST_BTN_IDX >= N_BTN) begin : g_bad_cfg
    $error("board_input_conditioner: illegal parameter set");
  end
  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    btn_debounce_ch #(
      .ACTIVE_HIGH     (ACTIVE_HIGH_MASK[i]),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
`ifdef BOARD_INPUT_LONG_PRESS_EN
      , .LONG_PRESS_CYCLES (LONG_PRESS_CYCLES)
`endif
    ) u_ch (
      .clk           (clk_100mhz),
      .rst_n         (ext_rst_n),
      .raw           (btn_raw[i]),
      .level         (btn_level[i]),
      .press_pulse   (btn_press[i]),
      .release_pulse (btn_release[i]),
      .long_pulse    (btn_long[i])
    );
  end
  localparam int HW = $clog2(RST_HOLD_CYCLES + 1);
  localparam logic [HW-1:0] HLAST = HW'(RST_HOLD_CYCLES - 1);
  rst_state_t state, state_nxt;
  logic [HW-1:0] hcnt, hcnt_nxt;
  logic rst_btn;
  assign rst_btn = btn_level[RST_BTN_IDX];
  always_ff @(posedge clk_100mhz)
    if (!ext_rst_n) begin
      state     <= RST_ASSERT;
      hcnt      <= '0;
      sys_rst_n <= 1'b0;
    end else begin
      state     <= state_nxt;
      hcnt      <= hcnt_nxt;
      sys_rst_n <= state_nxt == RUN;
    end
  // the reset button wins from every state; unused encodings fall back to RST_ASSERT
  always_comb begin
    state_nxt = rst_btn                           ? RST_ASSERT :
                state == RST_ASSERT               ? RST_HOLD   :
                state == RST_HOLD && hcnt == HLAST ? RUN        :
                state == RST_HOLD                 ? RST_HOLD   :
                state == RUN                      ? RUN        : RST_ASSERT;
    hcnt_nxt  = state == RST_HOLD ? hcnt + 1'b1 : '0;
  end
endmodule

// File: tb/tb_board_input_conditioner.sv
// tb_board_input_conditioner: directed checks of debounce, pulses, polarity and reset stretch.
module tb_board_input_conditioner;
  logic       clk_100mhz = 1'b0;
  logic       ext_rst_n;
  logic [3:0] btn_raw;
  logic [3:0] btn_level, btn_press, btn_release, btn_long;
  logic       sys_rst_n;
  int n_chk = 0;
  int n_fail = 0;
`ifdef BOARD_INPUT_LONG_PRESS_EN
  localparam logic [3:0] LONG_CH2 = 4'b0100;
`else
  localparam logic [3:0] LONG_CH2 = 4'b0000;
`endif
  board_input_conditioner #(
    .N_BTN             (4),
    .ACTIVE_HIGH_MASK  (4'b1101),
    .DEBOUNCE_CYCLES   (4),
    .RST_BTN_IDX       (0),
    .RST_HOLD_CYCLES   (8),
    .LONG_PRESS_CYCLES (10)
  ) dut (
    .clk_100mhz  (clk_100mhz),
    .ext_rst_n   (ext_rst_n),
    .btn_raw     (btn_raw),
    .btn_level   (btn_level),
    .btn_press   (btn_press),
    .btn_release (btn_release),
    .btn_long    (btn_long),
    .sys_rst_n   (sys_rst_n)
  );
  always #5 clk_100mhz = ~clk_100mhz;
  task automatic step(input int n);
    repeat (n) @(posedge clk_100mhz);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask
  task automatic chk_pulses(input string tag, input logic [3:0] lvl, input logic [3:0] prs, input logic [3:0] rel);
    chk({tag, "_level"}, btn_level, lvl);
    chk({tag, "_press"}, btn_press, prs);
    chk({tag, "_release"}, btn_release, rel);
  endtask
  initial begin
    ext_rst_n = 1'b0;
    btn_raw   = 4'b0010;
    for (int i = 0; i < 5; i++) begin
      step(1);
      btn_raw = 4'($urandom) & 4'b1110;
    end
    chk_pulses("rst", 4'b0000, 4'b0000, 4'b0000);
    chk("rst_long", btn_long, 0);
    chk("rst_sys", sys_rst_n, 0);
    ext_rst_n = 1'b1;
    btn_raw   = 4'b0010;
    step(8);
    chk("stretch_early", sys_rst_n, 0);
    step(1);
    chk("stretch_rise", sys_rst_n, 1);
    chk_pulses("idle", 4'b0000, 4'b0000, 4'b0000);
    btn_raw[2] = 1'b1;
    step(5);
    chk_pulses("ch2_pre", 4'b0000, 4'b0000, 4'b0000);
    step(1);
    chk_pulses("ch2_press", 4'b0100, 4'b0100, 4'b0000);
    step(1);
    chk_pulses("ch2_after", 4'b0100, 4'b0000, 4'b0000);
    step(8);
    chk("long_early", btn_long, 0);
    step(1);
    chk("long_pulse", btn_long, LONG_CH2);
    step(1);
    chk("long_once", btn_long, 0);
    step(3);
    chk_pulses("ch2_held", 4'b0100, 4'b0000, 4'b0000);
    chk("long_none", btn_long, 0);
    btn_raw[2] = 1'b0;
    step(5);
    chk_pulses("ch2_rel_pre", 4'b0100, 4'b0000, 4'b0000);
    step(1);
    chk_pulses("ch2_release", 4'b0000, 4'b0000, 4'b0100);
    step(1);
    chk_pulses("ch2_rel_after", 4'b0000, 4'b0000, 4'b0000);
    for (int i = 0; i < 30; i++) begin
      btn_raw[3] = ((i / 3) % 2) == 0;
      step(1);
      chk("bounce_quiet", {btn_level[3], btn_press[3], btn_release[3]}, 0);
    end
    btn_raw[3] = 1'b1;
    step(5);
    chk_pulses("ch3_pre", 4'b0000, 4'b0000, 4'b0000);
    step(1);
    chk_pulses("ch3_press", 4'b1000, 4'b1000, 4'b0000);
    step(1);
    chk_pulses("ch3_after", 4'b1000, 4'b0000, 4'b0000);
    btn_raw[3] = 1'b0;
    step(6);
    chk_pulses("ch3_release", 4'b0000, 4'b0000, 4'b1000);
    btn_raw[1] = 1'b0;
    step(5);
    chk_pulses("ch1_pre", 4'b0000, 4'b0000, 4'b0000);
    step(1);
    chk_pulses("ch1_press", 4'b0010, 4'b0010, 4'b0000);
    btn_raw[1] = 1'b1;
    step(6);
    chk_pulses("ch1_release", 4'b0000, 4'b0000, 4'b0010);
    btn_raw[3:2] = 2'b11;
    step(6);
    chk_pulses("simul_press", 4'b1100, 4'b1100, 4'b0000);
    btn_raw[3:2] = 2'b00;
    step(6);
    chk_pulses("simul_release", 4'b0000, 4'b0000, 4'b1100);
    chk("run_before_rbtn", sys_rst_n, 1);
    btn_raw[0] = 1'b1;
    step(6);
    chk_pulses("ch0_press", 4'b0001, 4'b0001, 4'b0000);
    chk("sys_still_high", sys_rst_n, 1);
    step(1);
    chk("sys_fall", sys_rst_n, 0);
    step(5);
    chk("sys_held_low", sys_rst_n, 0);
    btn_raw[0] = 1'b0;
    step(6);
    chk_pulses("ch0_release", 4'b0000, 4'b0000, 4'b0001);
    step(8);
    chk("rbtn_stretch_early", sys_rst_n, 0);
    step(1);
    chk("rbtn_stretch_rise", sys_rst_n, 1);
    btn_raw[0] = 1'b1;
    step(7);
    chk("repress_low", sys_rst_n, 0);
    btn_raw[0] = 1'b0;
    step(6);
    chk("repress_fall_lvl", btn_level, 0);
    btn_raw[0] = 1'b1;
    step(6);
    chk("hold_repress_lvl", btn_level, 4'b0001);
    btn_raw[0] = 1'b0;
    step(3);
    chk("hold_restart", sys_rst_n, 0);
    step(3);
    chk("hold_rel_lvl", btn_level, 0);
    step(8);
    chk("restart_early", sys_rst_n, 0);
    step(1);
    chk("restart_rise", sys_rst_n, 1);
    btn_raw[2] = 1'b1;
    step(6);
    chk("mid_lvl", btn_level, 4'b0100);
    ext_rst_n = 1'b0;
    step(1);
    chk_pulses("ext_mid", 4'b0000, 4'b0000, 4'b0000);
    chk("ext_mid_sys", sys_rst_n, 0);
    ext_rst_n = 1'b1;
    btn_raw   = 4'b0010;
    step(8);
    chk("ext_mid_early", sys_rst_n, 0);
    step(1);
    chk("ext_mid_rise", sys_rst_n, 1);
    chk("final_long", btn_long, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
